// File: rtl/unsigned_div.sv
// Restoring shift-subtract unsigned divider. One quotient bit per cycle, MSB first.
// Divide-by-zero is detected when the operands are accepted and finishes in a single cycle.
module unsigned_div #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastIter = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StZero} state_e;

  state_e          state_q;
  logic [N-1:0]    dvd_q;    // dividend bits shift out at the top, quotient bits shift in below
  logic [N-1:0]    dvs_q;
  logic [N:0]      rem_q;
  logic [CntW-1:0] cnt_q;

  logic [N:0]      rem_shift;
  logic [N:0]      rem_sub;
  logic            q_bit;
  logic [N:0]      rem_d;
  logic [N-1:0]    dvd_d;

  // After each restore step the partial remainder is below the divisor, so its MSB is always 0.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[N];

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q[N-1:0], dvd_q[N-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_d     = q_bit ? rem_sub : rem_shift;
    dvd_d     = {dvd_q[N-2:0], q_bit};
  end

  // Control FSM with registered results and status.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= (divisor == '0) ? StZero : StRun;
          end
        end
        StRun: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) begin
            quotient    <= dvd_d;
            remainder   <= rem_d[N-1:0];
            done        <= 1'b1;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StZero: begin
          // dvd_q was never shifted, so it still holds the latched dividend.
          quotient    <= '1;
          remainder   <= dvd_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
